jbi_min_rq_issue_ctl: RTL and testbench



---
 rtl/jbi_min_rq_issue_ctl.sv | 120 ++++++++++++
 tb/tb_jbi_min_rq_issue_ctl.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jbi_min_rq_issue_ctl.sv
// Issue side of the Request Header Queue: pops header entries and forwards them to SCTAG.
// Reads go out as one header beat; writes go out as a header beat followed by WDQ data beats.
module jbi_min_rq_issue_ctl #(
  parameter int CRD_MAX  = 2,
  parameter int WR_BEATS = 4,
  parameter int HDR_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rhq_drdy,
  input  logic             rhq_rdata_rw,
  input  logic [HDR_W-1:0] rhq_rdata_hdr,
  output logic             issue_rhq_pop,
  output logic             wdq_rd_en,
  input  logic [63:0]      wdq_rdata,
  output logic             sctag_req_vld,
  output logic [63:0]      sctag_req_data,
  output logic             sctag_req_last,
  input  logic             sctag_credit_ret,
  input  logic             csr_issue_stall,
  output logic             issue_busy,
  output logic [2:0]       issue_crd_cnt,
  output logic             issue_crd_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  localparam logic [2:0] CRD_MAX_C = 3'(CRD_MAX);
  localparam logic [2:0] BEAT_LAST = 3'(WR_BEATS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       beat_cnt;
  logic [HDR_W-1:0] hdr_q;
  logic             rw_q;
  logic [2:0]       crd_cnt;
  logic             crd_err;
  logic [63:0]      data_hold;
  logic             issue_go;

  assign issue_go = (state == IDLE) & rhq_drdy & (crd_cnt != 3'd0) & ~csr_issue_stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_go) state_nxt = HDR;
      HDR:     state_nxt = rw_q ? IDLE : DATA;
      DATA:    if (beat_cnt == BEAT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high so nothing leaks out of an abandoned transaction.
  always_comb begin
    issue_rhq_pop  = 1'b0;
    wdq_rd_en      = 1'b0;
    sctag_req_vld  = 1'b0;
    sctag_req_last = 1'b0;
    sctag_req_data = data_hold;
    case (state)
      IDLE: issue_rhq_pop = issue_go;
      HDR: begin
        sctag_req_vld  = ~rst;
        sctag_req_data = 64'(hdr_q);
        sctag_req_last = rw_q & ~rst;
        wdq_rd_en      = ~rw_q & ~rst;
      end
      DATA: begin
        sctag_req_vld  = ~rst;
        sctag_req_data = wdq_rdata;
        sctag_req_last = (beat_cnt == BEAT_LAST) & ~rst;
        wdq_rd_en      = (beat_cnt < BEAT_LAST) & ~rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= 3'd0;
      hdr_q     <= '0;
      rw_q      <= 1'b0;
      data_hold <= 64'd0;
    end else begin
      if (issue_go) begin
        hdr_q <= rhq_rdata_hdr;
        rw_q  <= rhq_rdata_rw;
      end
      if (state == HDR)
        beat_cnt <= 3'd0;
      else if (state == DATA && beat_cnt != BEAT_LAST)
        beat_cnt <= beat_cnt + 3'd1;
      if (sctag_req_vld)
        data_hold <= sctag_req_data;
    end
  end

  // A pop and a return in the same cycle cancel; a return at full count is an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      crd_cnt <= CRD_MAX_C;
      crd_err <= 1'b0;
    end else if (issue_rhq_pop && !sctag_credit_ret) begin
      crd_cnt <= crd_cnt - 3'd1;
    end else if (sctag_credit_ret && !issue_rhq_pop) begin
      if (crd_cnt == CRD_MAX_C) crd_err <= 1'b1;
      else                      crd_cnt <= crd_cnt + 3'd1;
    end
  end

  assign issue_busy    = (state != IDLE);
  assign issue_crd_cnt = crd_cnt;
  assign issue_crd_err = crd_err;

endmodule

// File: tb/tb_jbi_min_rq_issue_ctl.sv
// Self-checking bench for jbi_min_rq_issue_ctl: expected SCTAG beats are queued as entries are
// presented and matched against beats captured from the request interface.
module tb_jbi_min_rq_issue_ctl;

  localparam int CRD_MAX  = 2;
  localparam int WR_BEATS = 4;
  localparam int HDR_W    = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             rhq_drdy;
  logic             rhq_rdata_rw;
  logic [HDR_W-1:0] rhq_rdata_hdr;
  logic             issue_rhq_pop;
  logic             wdq_rd_en;
  logic [63:0]      wdq_rdata;
  logic             sctag_req_vld;
  logic [63:0]      sctag_req_data;
  logic             sctag_req_last;
  logic             sctag_credit_ret;
  logic             csr_issue_stall;
  logic             issue_busy;
  logic [2:0]       issue_crd_cnt;
  logic             issue_crd_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] exp_data[$];
  logic        exp_last[$];
  logic [63:0] obs_data[$];
  logic        obs_last[$];
  int          obs_rd = 0;

  int          pop_total = 0;
  int          rd_total  = 0;
  int          vld_total = 0;
  logic [63:0] wdq_base  = 64'h10;
  logic [63:0] wdq_ofs;

  jbi_min_rq_issue_ctl #(.CRD_MAX(CRD_MAX), .WR_BEATS(WR_BEATS), .HDR_W(HDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .rhq_drdy         (rhq_drdy),
    .rhq_rdata_rw     (rhq_rdata_rw),
    .rhq_rdata_hdr    (rhq_rdata_hdr),
    .issue_rhq_pop    (issue_rhq_pop),
    .wdq_rd_en        (wdq_rd_en),
    .wdq_rdata        (wdq_rdata),
    .sctag_req_vld    (sctag_req_vld),
    .sctag_req_data   (sctag_req_data),
    .sctag_req_last   (sctag_req_last),
    .sctag_credit_ret (sctag_credit_ret),
    .csr_issue_stall  (csr_issue_stall),
    .issue_busy       (issue_busy),
    .issue_crd_cnt    (issue_crd_cnt),
    .issue_crd_err    (issue_crd_err)
  );

  always #5 clk = ~clk;

  // WDQ model: data for a read strobe appears on the following cycle, counting up from wdq_base.
  always @(posedge clk) begin
    if (rst) begin
      wdq_ofs   <= 64'd0;
      wdq_rdata <= 64'd0;
    end else if (wdq_rd_en) begin
      wdq_rdata <= wdq_base + wdq_ofs;
      wdq_ofs   <= wdq_ofs + 64'd1;
    end
  end

  // Capture every request beat and keep running activity counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (sctag_req_vld) begin
        obs_data.push_back(sctag_req_data);
        obs_last.push_back(sctag_req_last);
        vld_total <= vld_total + 1;
      end
      if (issue_rhq_pop) pop_total <= pop_total + 1;
      if (wdq_rd_en)     rd_total  <= rd_total + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    rhq_drdy         = 1'b0;
    rhq_rdata_rw     = 1'b1;
    rhq_rdata_hdr    = '0;
    sctag_credit_ret = 1'b0;
    csr_issue_stall  = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_data.delete();
    exp_last.delete();
    @(negedge clk);
    obs_rd = obs_data.size();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({sctag_req_vld, sctag_req_last, issue_rhq_pop, wdq_rd_en, issue_busy} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: vld/last/pop/rd_en/busy=%b expected 00000",
               {sctag_req_vld, sctag_req_last, issue_rhq_pop, wdq_rd_en, issue_busy});
    end
    n_cmp++;
    if (sctag_req_data !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h expected 0", sctag_req_data);
    end
    n_cmp++;
    if (issue_crd_cnt !== 3'(CRD_MAX) || issue_crd_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_crd: cnt=%0d err=%b expected cnt=%0d err=0",
               issue_crd_cnt, issue_crd_err, CRD_MAX);
    end
  endtask

  task automatic test_read();
    logic [63:0] ed;
    logic        el;
    do_reset();
    rhq_drdy = 1'b1; rhq_rdata_rw = 1'b1; rhq_rdata_hdr = 64'hA5;
    exp_data.push_back(64'hA5); exp_last.push_back(1'b1);
    @(negedge clk);
    n_cmp++;
    if (issue_rhq_pop !== 1'b1) begin
      n_fail++; $display("[TB] FAIL read_pop: got %b expected 1", issue_rhq_pop);
    end
    step();
    rhq_drdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sctag_req_vld !== 1'b1 || sctag_req_last !== 1'b1 || issue_busy !== 1'b1 || issue_crd_cnt !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL read_hdr: vld=%b last=%b busy=%b cnt=%0d expected 1 1 1 1",
               sctag_req_vld, sctag_req_last, issue_busy, issue_crd_cnt);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (issue_busy !== 1'b0 || sctag_req_vld !== 1'b0 || sctag_req_data !== 64'hA5) begin
      n_fail++;
      $display("[TB] FAIL read_idle: busy=%b vld=%b data=%h expected busy=0 vld=0 data=a5",
               issue_busy, sctag_req_vld, sctag_req_data);
    end
    step();
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      n_cmp++;
      if (obs_rd >= obs_data.size()) begin
        n_fail++; $display("[TB] FAIL read_beat: no beat captured, expected data=%h last=%b", ed, el);
      end else begin
        if (obs_data[obs_rd] !== ed || obs_last[obs_rd] !== el) begin
          n_fail++;
          $display("[TB] FAIL read_beat: got data=%h last=%b expected data=%h last=%b",
                   obs_data[obs_rd], obs_last[obs_rd], ed, el);
        end
        obs_rd++;
      end
    end
  endtask

  task automatic test_write();
    logic [63:0] ed;
    logic        el;
    int          rd0;
    int          vld0;
    do_reset();
    wdq_base = 64'h10;
    rd0  = rd_total;
    vld0 = vld_total;
    rhq_drdy = 1'b1; rhq_rdata_rw = 1'b0; rhq_rdata_hdr = 64'h1234;
    exp_data.push_back(64'h1234); exp_last.push_back(1'b0);
    for (int k = 0; k < WR_BEATS; k++) begin
      exp_data.push_back(64'h10 + 64'(k));
      exp_last.push_back(k == WR_BEATS - 1);
    end
    @(negedge clk);
    n_cmp++;
    if (issue_rhq_pop !== 1'b1) begin
      n_fail++; $display("[TB] FAIL write_pop: got %b expected 1", issue_rhq_pop);
    end
    step();
    rhq_drdy = 1'b0;
    for (int i = 0; i < WR_BEATS + 3; i++) step();
    n_cmp++;
    if (rd_total - rd0 !== WR_BEATS) begin
      n_fail++; $display("[TB] FAIL write_rd_en: got %0d cycles expected %0d", rd_total - rd0, WR_BEATS);
    end
    n_cmp++;
    if (vld_total - vld0 !== WR_BEATS + 1) begin
      n_fail++; $display("[TB] FAIL write_vld: got %0d cycles expected %0d", vld_total - vld0, WR_BEATS + 1);
    end
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      n_cmp++;
      if (obs_rd >= obs_data.size()) begin
        n_fail++; $display("[TB] FAIL write_beat: no beat captured, expected data=%h last=%b", ed, el);
      end else begin
        if (obs_data[obs_rd] !== ed || obs_last[obs_rd] !== el) begin
          n_fail++;
          $display("[TB] FAIL write_beat: got data=%h last=%b expected data=%h last=%b",
                   obs_data[obs_rd], obs_last[obs_rd], ed, el);
        end
        obs_rd++;
      end
    end
  endtask

  task automatic test_credit_exhaust();
    logic [63:0] ed;
    logic        el;
    int          pops;
    logic [2:0]  cnt_last;
    do_reset();
    pops = 0;
    cnt_last = 3'd7;
    rhq_drdy = 1'b1; rhq_rdata_rw = 1'b1; rhq_rdata_hdr = 64'hB0;
    for (int k = 0; k < 3; k++) begin
      exp_data.push_back(64'hB0 + 64'(k)); exp_last.push_back(1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (issue_rhq_pop === 1'b1) pops++;
      cnt_last = issue_crd_cnt;
      step();
      rhq_rdata_hdr = 64'hB0 + 64'(pops);
    end
    n_cmp++;
    if (pops !== 2 || cnt_last !== 3'd0) begin
      n_fail++; $display("[TB] FAIL crd_exhaust: pops=%0d cnt=%0d expected pops=2 cnt=0", pops, cnt_last);
    end
    sctag_credit_ret = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (issue_rhq_pop !== 1'b0) begin
      n_fail++; $display("[TB] FAIL crd_ret_cycle: pop=%b expected 0", issue_rhq_pop);
    end
    step();
    sctag_credit_ret = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (issue_rhq_pop !== 1'b1 || issue_crd_cnt !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL crd_resume: pop=%b cnt=%0d expected pop=1 cnt=1", issue_rhq_pop, issue_crd_cnt);
    end
    step();
    rhq_drdy = 1'b0;
    step();
    step();
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      n_cmp++;
      if (obs_rd >= obs_data.size()) begin
        n_fail++; $display("[TB] FAIL crd_beat: no beat captured, expected data=%h last=%b", ed, el);
      end else begin
        if (obs_data[obs_rd] !== ed || obs_last[obs_rd] !== el) begin
          n_fail++;
          $display("[TB] FAIL crd_beat: got data=%h last=%b expected data=%h last=%b",
                   obs_data[obs_rd], obs_last[obs_rd], ed, el);
        end
        obs_rd++;
      end
    end
  endtask

  task automatic test_credit_simul();
    do_reset();
    rhq_drdy = 1'b1; rhq_rdata_rw = 1'b1; rhq_rdata_hdr = 64'hC0;
    @(negedge clk);
    step();
    rhq_drdy = 1'b0;
    step();
    rhq_drdy = 1'b1; rhq_rdata_hdr = 64'hC1; sctag_credit_ret = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (issue_rhq_pop !== 1'b1 || issue_crd_cnt !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL simul_pre: pop=%b cnt=%0d expected pop=1 cnt=1", issue_rhq_pop, issue_crd_cnt);
    end
    step();
    rhq_drdy = 1'b0; sctag_credit_ret = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (issue_crd_cnt !== 3'd1) begin
      n_fail++; $display("[TB] FAIL simul_cnt: got %0d expected 1", issue_crd_cnt);
    end
    step();
    sctag_credit_ret = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if (issue_crd_cnt !== 3'd2 || issue_crd_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL crd_full: cnt=%0d err=%b expected cnt=2 err=0", issue_crd_cnt, issue_crd_err);
    end
    step();
    sctag_credit_ret = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (issue_crd_cnt !== 3'd2 || issue_crd_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL crd_overflow: cnt=%0d err=%b expected cnt=2 err=1", issue_crd_cnt, issue_crd_err);
    end
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    n_cmp++;
    if (issue_crd_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL crd_err_sticky: got %b expected 1", issue_crd_err);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (issue_crd_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL crd_err_clear: got %b expected 0", issue_crd_err);
    end
  endtask

  task automatic test_stall();
    logic [63:0] ed;
    logic        el;
    int          stall_pops;
    do_reset();
    wdq_base = 64'h20;
    stall_pops = 0;
    rhq_drdy = 1'b1; rhq_rdata_rw = 1'b0; rhq_rdata_hdr = 64'hD0;
    exp_data.push_back(64'hD0); exp_last.push_back(1'b0);
    for (int k = 0; k < WR_BEATS; k++) begin
      exp_data.push_back(64'h20 + 64'(k)); exp_last.push_back(k == WR_BEATS - 1);
    end
    exp_data.push_back(64'hD1); exp_last.push_back(1'b1);
    @(negedge clk);
    step();
    rhq_rdata_rw = 1'b1; rhq_rdata_hdr = 64'hD1;
    @(negedge clk);
    if (issue_rhq_pop === 1'b1) stall_pops++;
    step();
    csr_issue_stall = 1'b1;
    for (int i = 2; i <= WR_BEATS + 3; i++) begin
      @(negedge clk);
      if (issue_rhq_pop === 1'b1) stall_pops++;
      step();
    end
    n_cmp++;
    if (stall_pops !== 0 || issue_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: pops=%0d busy=%b expected pops=0 busy=0", stall_pops, issue_busy);
    end
    csr_issue_stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (issue_rhq_pop !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_resume: pop=%b expected 1", issue_rhq_pop);
    end
    step();
    rhq_drdy = 1'b0;
    step();
    step();
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      n_cmp++;
      if (obs_rd >= obs_data.size()) begin
        n_fail++; $display("[TB] FAIL stall_beat: no beat captured, expected data=%h last=%b", ed, el);
      end else begin
        if (obs_data[obs_rd] !== ed || obs_last[obs_rd] !== el) begin
          n_fail++;
          $display("[TB] FAIL stall_beat: got data=%h last=%b expected data=%h last=%b",
                   obs_data[obs_rd], obs_last[obs_rd], ed, el);
        end
        obs_rd++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] ed;
    logic        el;
    int          rd_after;
    do_reset();
    wdq_base = 64'h30;
    rhq_drdy = 1'b1; rhq_rdata_rw = 1'b0; rhq_rdata_hdr = 64'hE0;
    exp_data.push_back(64'hE0); exp_last.push_back(1'b0);
    exp_data.push_back(64'h30); exp_last.push_back(1'b0);
    @(negedge clk);
    step();
    rhq_drdy = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sctag_req_vld !== 1'b0 || issue_busy !== 1'b0 || issue_crd_cnt !== 3'(CRD_MAX)) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: vld=%b busy=%b cnt=%0d expected vld=0 busy=0 cnt=%0d",
               sctag_req_vld, issue_busy, issue_crd_cnt, CRD_MAX);
    end
    rd_after = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wdq_rd_en === 1'b1 || sctag_req_vld === 1'b1) rd_after++;
      step();
    end
    n_cmp++;
    if (rd_after !== 0) begin
      n_fail++; $display("[TB] FAIL mid_reset_quiet: active cycles=%0d expected 0", rd_after);
    end
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      n_cmp++;
      if (obs_rd >= obs_data.size()) begin
        n_fail++; $display("[TB] FAIL mid_beat: no beat captured, expected data=%h last=%b", ed, el);
      end else begin
        if (obs_data[obs_rd] !== ed || obs_last[obs_rd] !== el) begin
          n_fail++;
          $display("[TB] FAIL mid_beat: got data=%h last=%b expected data=%h last=%b",
                   obs_data[obs_rd], obs_last[obs_rd], ed, el);
        end
        obs_rd++;
      end
    end
    n_cmp++;
    if (obs_rd != obs_data.size()) begin
      n_fail++;
      $display("[TB] FAIL mid_extra: beats seen=%0d expected %0d", obs_data.size() - obs_rd + 2, 2);
    end
  endtask

  // Guard against a hung run; all tests use fixed cycle counts so this should never fire.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run time limit reached, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst = 1'b1;
    rhq_drdy = 1'b0; rhq_rdata_rw = 1'b1; rhq_rdata_hdr = '0;
    sctag_credit_ret = 1'b0; csr_issue_stall = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_credit_exhaust();
    test_credit_simul();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
